// File: rtl/seq_register_file_sb_if.sv
`default_nettype none
// Issue/decode/writeback bundle for seq_register_file_sb.
// master drives the register file, slave is the register file itself.
interface seq_register_file_sb_if #(
  parameter int DATA_SIZE = 32,
  parameter int REG_COUNT = 8,
  parameter int ADDR_SIZE = 3
);
  logic [ADDR_SIZE-1:0] i_source1;
  logic [ADDR_SIZE-1:0] i_source2;
  logic                 i_source1_used;
  logic                 i_source2_used;
  logic [ADDR_SIZE-1:0] i_destination;
  logic [DATA_SIZE-1:0] i_result;
  logic                 i_register_file_write;
  logic                 i_reserve;
  logic [ADDR_SIZE-1:0] i_reserve_dest;
  logic                 i_flush;
  logic [DATA_SIZE-1:0] o_operand1;
  logic [DATA_SIZE-1:0] o_operand2;
  logic                 o_stall;
  logic [REG_COUNT-1:0] o_pending_mask;
  logic                 o_reserve_conflict;

  modport master (
    output i_source1, i_source2, i_source1_used, i_source2_used,
           i_destination, i_result, i_register_file_write,
           i_reserve, i_reserve_dest, i_flush,
    input  o_operand1, o_operand2, o_stall, o_pending_mask, o_reserve_conflict
  );

  modport slave (
    input  i_source1, i_source2, i_source1_used, i_source2_used,
           i_destination, i_result, i_register_file_write,
           i_reserve, i_reserve_dest, i_flush,
    output o_operand1, o_operand2, o_stall, o_pending_mask, o_reserve_conflict
  );
endinterface
`default_nettype wire

// File: rtl/seq_register_file_sb.sv
`default_nettype none
// Register file with two async read ports, one sync write port, write bypass,
// optional hardwired-zero R0 and a per-register pending-write scoreboard.
module seq_register_file_sb #(
  parameter int DATA_SIZE = 32,
  parameter int REG_COUNT = 8,
  parameter int ADDR_SIZE = 3,
  parameter int ZERO_REG  = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  seq_register_file_sb_if.slave  bus
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_SIZE-1:0] regs [REG_COUNT];
  logic [REG_COUNT-1:0] pending;
  logic [REG_COUNT-1:0] pending_next;
  logic                 conflict;
  logic                 conflict_set;

  logic src1_zero, src2_zero;
  logic bypass1, bypass2;
  logic commit;
  logic reserve_eff;

  always_comb begin
    src1_zero   = HAS_ZERO && (bus.i_source1 == '0);
    src2_zero   = HAS_ZERO && (bus.i_source2 == '0);
    bypass1     = bus.i_register_file_write && (bus.i_destination == bus.i_source1) && !src1_zero;
    bypass2     = bus.i_register_file_write && (bus.i_destination == bus.i_source2) && !src2_zero;
    commit      = bus.i_register_file_write && !(HAS_ZERO && (bus.i_destination == '0));
    reserve_eff = bus.i_reserve && !(HAS_ZERO && (bus.i_reserve_dest == '0));
  end

  always_comb begin
    bus.o_operand1 = src1_zero ? '0 : (bypass1 ? bus.i_result : regs[bus.i_source1]);
    bus.o_operand2 = src2_zero ? '0 : (bypass2 ? bus.i_result : regs[bus.i_source2]);
    bus.o_stall    = (bus.i_source1_used && pending[bus.i_source1] && !bypass1) ||
                     (bus.i_source2_used && pending[bus.i_source2] && !bypass2);
    bus.o_pending_mask     = pending;
    bus.o_reserve_conflict = conflict;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int n = 0; n < REG_COUNT; n++) begin
        regs[n] <= '0;
      end
    end else if (commit) begin
      regs[bus.i_destination] <= bus.i_result;
    end
  end

  // Reserve is applied after the write-clear so a new producer supersedes the old one.
  always_comb begin
    pending_next = pending;
    if (bus.i_flush) begin
      pending_next = '0;
    end else begin
      if (bus.i_register_file_write) begin
        pending_next[bus.i_destination] = 1'b0;
      end
      if (reserve_eff) begin
        pending_next[bus.i_reserve_dest] = 1'b1;
      end
    end
  end

  always_comb begin
    conflict_set = reserve_eff && !bus.i_flush && pending[bus.i_reserve_dest] &&
                   !(bus.i_register_file_write && (bus.i_destination == bus.i_reserve_dest));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending  <= '0;
      conflict <= 1'b0;
    end else begin
      pending  <= pending_next;
      conflict <= conflict | conflict_set;
    end
  end

endmodule
`default_nettype wire
